// File: rtl/alu_seq_ctrl.sv
// Clocked sequencer driving a dual-rail ALU through precharge/evaluate phases and returning a single-rail result.
// Optional PRE/EVAL watchdog: define ALU_SEQ_TIMEOUT_EN.
module alu_seq_ctrl #(
    parameter int WIDTH            = 32,
    parameter int PRECHARGE_CYCLES = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ctrl,
    input  logic [WIDTH-1:0] req_rs,
    input  logic [WIDTH-1:0] req_rt,
    output logic             alu_precharge,
    output logic [3:0]       alu_ctrl_t,
    output logic [3:0]       alu_ctrl_f,
    output logic [WIDTH-1:0] alu_rs_t,
    output logic [WIDTH-1:0] alu_rs_f,
    output logic [WIDTH-1:0] alu_rt_t,
    output logic [WIDTH-1:0] alu_rt_f,
    input  logic             alu_complete,
    input  logic [WIDTH-1:0] alu_result_t,
    input  logic [WIDTH-1:0] alu_result_f,
    input  logic             alu_zero_t,
    input  logic             alu_zero_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [1:0]       rsp_err,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, PRE, EVAL, CAP, RSP} state_t;

    localparam int PW = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             cmp_s;
    logic [PW-1:0]    pre_cnt_q;
    logic             pre_done;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] rs_q, rt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, rail_err_q, timeout_q;
    logic             drive, rail_bad, timeout_hit, wait_expired;

    assign cmp_s    = sync_q[SYNC_STAGES-1];
    assign pre_done = (pre_cnt_q == PW'(PRECHARGE_CYCLES - 1));
    // A bit pair with t==f is either still null or illegal; both are encoding errors at capture.
    assign rail_bad = (|(~(alu_result_t ^ alu_result_f))) | ~(alu_zero_t ^ alu_zero_f);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt_q;

    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)
            wait_cnt_q <= '0;
        else if (state_d != state_q)
            wait_cnt_q <= '0;
        else if (state_q == PRE || state_q == EVAL)
            wait_cnt_q <= wait_cnt_q + TW'(1);
    end
`else
    assign wait_expired = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: if (req_valid) state_d = PRE;
            PRE: begin
                if (pre_done && !cmp_s) begin
                    state_d = EVAL;
                end else if (wait_expired) begin
                    state_d     = RSP;
                    timeout_hit = 1'b1;
                end
            end
            EVAL: begin
                if (cmp_s) begin
                    state_d = CAP;
                end else if (wait_expired) begin
                    state_d     = RSP;
                    timeout_hit = 1'b1;
                end
            end
            CAP:     state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            pre_cnt_q  <= '0;
            ctrl_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            rail_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], alu_complete};

            if (state_q != PRE)
                pre_cnt_q <= '0;
            else if (!pre_done)
                pre_cnt_q <= pre_cnt_q + PW'(1);

            if (state_q == IDLE && req_valid) begin
                ctrl_q <= req_ctrl;
                rs_q   <= req_rs;
                rt_q   <= req_rt;
            end

            if (state_q == CAP) begin
                result_q   <= rail_bad ? '0 : alu_result_t;
                zero_q     <= alu_zero_t & ~rail_bad;
                rail_err_q <= rail_bad;
                timeout_q  <= 1'b0;
            end else if (timeout_hit) begin
                result_q   <= '0;
                zero_q     <= 1'b0;
                rail_err_q <= 1'b0;
                timeout_q  <= 1'b1;
            end
        end
    end

    // Rails carry a codeword only in EVAL/CAP; every other state is the null spacer.
    assign drive         = (state_q == EVAL) || (state_q == CAP);
    assign alu_precharge = ~drive;
    assign alu_ctrl_t    = {4{drive}} & ctrl_q;
    assign alu_ctrl_f    = {4{drive}} & ~ctrl_q;
    assign alu_rs_t      = {WIDTH{drive}} & rs_q;
    assign alu_rs_f      = {WIDTH{drive}} & ~rs_q;
    assign alu_rt_t      = {WIDTH{drive}} & rt_q;
    assign alu_rt_f      = {WIDTH{drive}} & ~rt_q;

    assign req_ready  = reset_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RSP);
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = {timeout_q, rail_err_q};

endmodule
